// File: rtl/cc_gate_logic_pkg.sv
// Shared encodings for the gate-logic pipe: operation select codes and buffer occupancy states.
package cc_gate_logic_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fifo_state_e;

endpackage

// File: rtl/cc_gate_logic_fifo.sv
// Result buffer: DEPTH entries of WIDTH bits, wrapping pointers, count and occupancy state.
// Head reads as zero while empty; reset clears every entry.
module cc_gate_logic_fifo
    import cc_gate_logic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_valid,
    output logic             o_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fifo_state_e                   r_state;
    fifo_state_e                   w_state_next;
    logic [CW-1:0]                 r_count;
    logic [CW-1:0]                 w_count_next;
    logic [PW-1:0]                 r_wr_ptr;
    logic [PW-1:0]                 r_rd_ptr;
    logic                          w_push;
    logic                          w_pop;
    logic [DEPTH-1:0][WIDTH-1:0]   w_entries;

    assign w_push = i_push && (r_state != FULL);
    assign w_pop  = i_pop  && (r_state != EMPTY);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] r_entry;

        always_ff @(posedge clk) begin
            if (srst) begin
                r_entry <= '0;
            end else if (w_push && (r_wr_ptr == PW'(gi))) begin
                r_entry <= i_push_data;
            end
        end

        assign w_entries[gi] = r_entry;
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase

        w_state_next = PARTIAL;
        if (w_count_next == '0) begin
            w_state_next = EMPTY;
        end else if (w_count_next == CW'(DEPTH)) begin
            w_state_next = FULL;
        end
    end

    // DEPTH is a power of two, so plain increment wraps DEPTH-1 -> 0.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state  <= EMPTY;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    assign o_valid = (r_state != EMPTY);
    assign o_ready = (r_state != FULL);
    assign o_head  = (r_state == EMPTY) ? '0 : w_entries[r_rd_ptr];

endmodule

// File: rtl/cc_gate_logic_pipe.sv
// Bitwise gate pipe: AND/OR/XOR/NAND of two operands, results queued with valid/ready on both sides.
// Define CC_GATE_LOGIC_PIPE_ZERO_FLAG_EN to add the per-entry zero flag output.
module cc_gate_logic_pipe
    import cc_gate_logic_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 8,
    parameter int DEPTH         = 2
) (
    input  logic                     CC_GATE_LOGIC_PIPE_CLOCK_50,
    input  logic                     CC_GATE_LOGIC_PIPE_RESET_InHigh,
    input  logic [DATAWIDTH_BUS-1:0] CC_GATE_LOGIC_PIPE_a_In,
    input  logic [DATAWIDTH_BUS-1:0] CC_GATE_LOGIC_PIPE_b_In,
    input  logic [1:0]               CC_GATE_LOGIC_PIPE_op_In,
    input  logic                     CC_GATE_LOGIC_PIPE_valid_In,
    output logic                     CC_GATE_LOGIC_PIPE_ready_Out,
    output logic [DATAWIDTH_BUS-1:0] CC_GATE_LOGIC_PIPE_z_Out,
    output logic                     CC_GATE_LOGIC_PIPE_valid_Out,
`ifdef CC_GATE_LOGIC_PIPE_ZERO_FLAG_EN
    output logic                     CC_GATE_LOGIC_PIPE_zero_Out,
`endif
    input  logic                     CC_GATE_LOGIC_PIPE_ready_In
);

`ifdef CC_GATE_LOGIC_PIPE_ZERO_FLAG_EN
    localparam int FW = DATAWIDTH_BUS + 1;
`else
    localparam int FW = DATAWIDTH_BUS;
`endif

    logic [DATAWIDTH_BUS-1:0] w_result;
    logic [FW-1:0]            w_push_data;
    logic [FW-1:0]            w_head;
    logic                     w_push;
    logic                     w_pop;

    always_comb begin
        w_result = '0;
        case (CC_GATE_LOGIC_PIPE_op_In)
            OP_AND:  w_result = CC_GATE_LOGIC_PIPE_a_In & CC_GATE_LOGIC_PIPE_b_In;
            OP_OR:   w_result = CC_GATE_LOGIC_PIPE_a_In | CC_GATE_LOGIC_PIPE_b_In;
            OP_XOR:  w_result = CC_GATE_LOGIC_PIPE_a_In ^ CC_GATE_LOGIC_PIPE_b_In;
            OP_NAND: w_result = ~(CC_GATE_LOGIC_PIPE_a_In & CC_GATE_LOGIC_PIPE_b_In);
            default: w_result = '0;
        endcase
    end

    // Handshakes qualify on registered occupancy only, so ready never depends on ready_In.
    assign w_push = CC_GATE_LOGIC_PIPE_valid_In && CC_GATE_LOGIC_PIPE_ready_Out;
    assign w_pop  = CC_GATE_LOGIC_PIPE_valid_Out && CC_GATE_LOGIC_PIPE_ready_In;

`ifdef CC_GATE_LOGIC_PIPE_ZERO_FLAG_EN
    assign w_push_data                 = {(w_result == '0), w_result};
    assign CC_GATE_LOGIC_PIPE_z_Out    = w_head[DATAWIDTH_BUS-1:0];
    assign CC_GATE_LOGIC_PIPE_zero_Out = w_head[DATAWIDTH_BUS];
`else
    assign w_push_data                 = w_result;
    assign CC_GATE_LOGIC_PIPE_z_Out    = w_head;
`endif

    cc_gate_logic_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (CC_GATE_LOGIC_PIPE_CLOCK_50),
        .srst        (CC_GATE_LOGIC_PIPE_RESET_InHigh),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_valid     (CC_GATE_LOGIC_PIPE_valid_Out),
        .o_ready     (CC_GATE_LOGIC_PIPE_ready_Out)
    );

endmodule

// File: tb/tb_cc_gate_logic_pipe.sv
// Scoreboard bench: instance 0 (DEPTH=2) gets directed sequences, instance 1 (DEPTH=4) a random stream.
module tb_cc_gate_logic_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a    [2];
    logic [7:0] b    [2];
    logic [1:0] op   [2];
    logic       vin  [2];
    logic       rin  [2];
    logic       rout [2];
    logic       vout [2];
    logic [7:0] z    [2];
    logic       zf   [2];

    int checks   = 0;
    int failures = 0;
    int qsize  [2];
    int pushed [2];
    logic [7:0] pop_log0 [$];

    always #5 clk = ~clk;

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d actual=0x%0h required=0x%0h t=%0t", name, inst, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o);
        case (o)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return ~(x & y);
        endcase
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int D = (gi == 0) ? 2 : 4;
        logic [7:0] exp_q [$];
        logic [7:0] head;
        int         sz;

        cc_gate_logic_pipe #(.DATAWIDTH_BUS(8), .DEPTH(D)) u_dut (
            .CC_GATE_LOGIC_PIPE_CLOCK_50     (clk),
            .CC_GATE_LOGIC_PIPE_RESET_InHigh (rst),
            .CC_GATE_LOGIC_PIPE_a_In         (a[gi]),
            .CC_GATE_LOGIC_PIPE_b_In         (b[gi]),
            .CC_GATE_LOGIC_PIPE_op_In        (op[gi]),
            .CC_GATE_LOGIC_PIPE_valid_In     (vin[gi]),
            .CC_GATE_LOGIC_PIPE_ready_Out    (rout[gi]),
            .CC_GATE_LOGIC_PIPE_z_Out        (z[gi]),
            .CC_GATE_LOGIC_PIPE_valid_Out    (vout[gi]),
`ifdef CC_GATE_LOGIC_PIPE_ZERO_FLAG_EN
            .CC_GATE_LOGIC_PIPE_zero_Out     (zf[gi]),
`endif
            .CC_GATE_LOGIC_PIPE_ready_In     (rin[gi])
        );

`ifndef CC_GATE_LOGIC_PIPE_ZERO_FLAG_EN
        assign zf[gi] = 1'b0;
`endif

        // Monitor: compare outputs with the queue model, then apply this cycle's transfer.
        initial begin
            @(posedge clk);
            forever begin
                @(negedge clk);
                sz   = exp_q.size();
                head = (sz != 0) ? exp_q[0] : 8'h00;
                check("valid_out", gi, vout[gi], sz != 0);
                check("ready_out", gi, rout[gi], sz != D);
                check("z_out", gi, z[gi], head);
`ifdef CC_GATE_LOGIC_PIPE_ZERO_FLAG_EN
                check("zero_out", gi, zf[gi], (sz != 0) && (head == 8'h00));
`endif
                if (rst) begin
                    exp_q.delete();
                end else begin
                    if (sz != 0 && rin[gi]) begin
                        void'(exp_q.pop_front());
                        if (gi == 0) pop_log0.push_back(z[gi]);
                        $display("inst%0d pop  z=0x%02h t=%0t", gi, z[gi], $time);
                    end
                    if (vin[gi] && sz < D) begin
                        exp_q.push_back(ref_op(a[gi], b[gi], op[gi]));
                        pushed[gi]++;
                        $display("inst%0d push a=0x%02h b=0x%02h op=%0d exp=0x%02h t=%0t",
                                 gi, a[gi], b[gi], op[gi], ref_op(a[gi], b[gi], op[gi]), $time);
                    end
                end
                qsize[gi] = exp_q.size();
            end
        end
    end

    task automatic drive(input int i, input logic v, input logic [7:0] x, input logic [7:0] y,
                         input logic [1:0] o, input logic r);
        vin[i] = v; a[i] = x; b[i] = y; op[i] = o; rin[i] = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog inst0 actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp31 [4];
        int         budget;
        exp31[0] = 8'h30; exp31[1] = 8'hFC; exp31[2] = 8'hCC; exp31[3] = 8'hCF;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(i, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0);
            qsize[i] = 0; pushed[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step();
        check("reset_valid", 0, vout[0], 1'b0);
        check("reset_ready", 0, rout[0], 1'b1);
        check("reset_z", 0, z[0], 8'h00);

        // Four ops on F0/3C, downstream always ready.
        pop_log0.delete();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b1, 8'hF0, 8'h3C, 2'(k), 1'b1);
            step();
        end
        drive(0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
        repeat (3) step();
        check("ops_count", 0, pop_log0.size(), 4);
        for (int k = 0; k < 4 && k < pop_log0.size(); k++) begin
            check("ops_value", 0, pop_log0[k], exp31[k]);
        end

        // Fill DEPTH=2 with a stalled sink; third pair must be refused.
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b1, 8'(8'h11 * (k + 1)), 8'h0F, 2'd1, 1'b0);
            step();
        end
        drive(0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0);
        check("full_ready", 0, rout[0], 1'b0);
        check("full_head", 0, z[0], 8'h1F);
        repeat (2) step();

        // FULL with valid_In and ready_In together: pop only, ready returns next cycle.
        drive(0, 1'b1, 8'hAA, 8'h55, 2'd2, 1'b1);
        step();
        drive(0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0);
        check("full_pop_ready", 0, rout[0], 1'b1);
        check("full_pop_head", 0, z[0], 8'h2F);
        drive(0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
        repeat (2) step();

        // Reset with two entries buffered and a transfer pending.
        for (int k = 0; k < 2; k++) begin
            drive(0, 1'b1, 8'h5A, 8'(k), 2'd0, 1'b0);
            step();
        end
        drive(0, 1'b1, 8'h77, 8'h77, 2'd1, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0);
        check("rst_valid", 0, vout[0], 1'b0);
        check("rst_z", 0, z[0], 8'h00);
        drive(0, 1'b1, 8'hFF, 8'hFF, 2'd2, 1'b0);
        step();
        drive(0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0);
        check("xor_ff_valid", 0, vout[0], 1'b1);
        check("xor_ff_z", 0, z[0], 8'h00);
`ifdef CC_GATE_LOGIC_PIPE_ZERO_FLAG_EN
        check("xor_ff_zero", 0, zf[0], 1'b1);
`endif
        drive(0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
        repeat (2) step();

        // Random stream of 20 accepted pushes on DEPTH=4 with random sink stalls.
        budget = 0;
        while (pushed[1] < 20 && budget < 2000) begin
            drive(1, ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            step();
            budget++;
        end
        drive(1, 1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
        check("stream_pushed", 1, pushed[1], 20);
        budget = 0;
        while (qsize[1] != 0 && budget < 200) begin
            step();
            budget++;
        end
        check("stream_drained", 1, qsize[1], 0);
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
